commit_trace_sink: RTL and testbench

- Receiving end of the CPU difftest commit stream: diffen, diffPC, diffInstr, nextPC.
- Captures every retired-instruction record into a small FIFO and tags it with a sequence number.
- Drains records to the simulation harness over a valid/ready interface, so the harness can consume at its own pace.
- Checks PC continuity between consecutive commits (nextPC of commit N must equal PC of commit N+1) and flags overflow and chain breaks as sticky errors.

---
 rtl/commit_trace_sink.sv | 95 +++++++++
 tb/tb_commit_trace_sink.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_sink.sv
// commit_trace_sink: difftest commit FIFO with seq tagging, overflow and PC-chain checks.
// Define COMMIT_TRACE_HALT_EN to add a halt output that freezes capture after an ebreak.
module commit_trace_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int SEQ_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    diffen,
  input  logic [DATA_WIDTH-1:0]   diffPC,
  input  logic [DATA_WIDTH-1:0]   diffInstr,
  input  logic [DATA_WIDTH-1:0]   nextPC,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0]   out_instr,
  output logic [DATA_WIDTH-1:0]   out_npc,
  output logic [SEQ_WIDTH-1:0]    out_seq,
  output logic [$clog2(DEPTH):0]  count,
`ifdef COMMIT_TRACE_HALT_EN
  output logic                    halt,
`endif
  output logic                    overflow,
  output logic [15:0]             drop_cnt,
  output logic                    chain_err,
  output logic [DATA_WIDTH-1:0]   err_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] npc;
    logic [SEQ_WIDTH-1:0]  seq;
  } rec_t;
  rec_t mem [DEPTH];
  rec_t head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SEQ_WIDTH-1:0] seq;
  logic have_last;
  logic [DATA_WIDTH-1:0] last_npc;
  logic commit, full, pop, push, drop;
`ifdef COMMIT_TRACE_HALT_EN
  assign commit = diffen & ~halt;
`else
  assign commit = diffen;
`endif
  assign full = count == FULL_CNT;
  assign out_valid = count != '0;
  assign pop = out_valid & out_ready;
  // a full FIFO still accepts a commit when the head leaves in the same cycle
  assign push = commit & (~full | pop);
  assign drop = commit & full & ~pop;
  assign head = mem[rd_ptr];
  assign out_pc = out_valid ? head.pc : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_npc = out_valid ? head.npc : '0;
  assign out_seq = out_valid ? head.seq : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {diffPC, diffInstr, nextPC, seq};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      seq <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      chain_err <= 1'b0;
      err_pc <= '0;
      have_last <= 1'b0;
      last_npc <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (commit) begin
        seq <= seq + 1'b1;
        have_last <= 1'b1;
        last_npc <= nextPC;
        if (have_last && diffPC != last_npc) begin
          chain_err <= 1'b1;
          if (!chain_err) err_pc <= diffPC;
        end
      end
    end
`ifdef COMMIT_TRACE_HALT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) halt <= 1'b0;
    else if (push && diffInstr == DATA_WIDTH'(32'h00100073)) halt <= 1'b1;
`endif
endmodule

// File: tb/tb_commit_trace_sink.sv
// tb_commit_trace_sink: directed scoreboard bench for commit_trace_sink (DEPTH=8).
module tb_commit_trace_sink;
  logic clk = 1'b0, rst = 1'b0, diffen = 1'b0, out_ready = 1'b0;
  logic [31:0] diffPC = '0, diffInstr = '0, nextPC = '0;
  logic out_valid, overflow, chain_err;
  logic [31:0] out_pc, out_instr, out_npc, out_seq, err_pc;
  logic [3:0] count;
  logic [15:0] drop_cnt;
`ifdef COMMIT_TRACE_HALT_EN
  logic halt;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] pc, instr, npc, seq;
  } rec_t;
  rec_t sb[$];
  int m_count;
  logic [31:0] m_seq, m_lnpc, m_errpc;
  logic [15:0] m_drop;
  bit m_ovf, m_chain, m_have, m_halt;

  commit_trace_sink dut (
    .clk(clk), .rst(rst), .diffen(diffen), .diffPC(diffPC), .diffInstr(diffInstr),
    .nextPC(nextPC), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_npc(out_npc), .out_seq(out_seq), .count(count),
`ifdef COMMIT_TRACE_HALT_EN
    .halt(halt),
`endif
    .overflow(overflow), .drop_cnt(drop_cnt), .chain_err(chain_err), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_count = 0; m_seq = '0; m_lnpc = '0; m_errpc = '0; m_drop = '0;
    m_ovf = 0; m_chain = 0; m_have = 0; m_halt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; diffen = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, count, m_count);
    chk({tag, ".valid"}, out_valid, m_count != 0);
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".drop"}, drop_cnt, m_drop);
    chk({tag, ".chain"}, chain_err, m_chain);
    chk({tag, ".errpc"}, err_pc, m_errpc);
`ifdef COMMIT_TRACE_HALT_EN
    chk({tag, ".halt"}, halt, m_halt);
`endif
  endtask

  // one clock: drive at negedge, check/pop the head, update the model, wait for the edge
  task automatic step(input bit en, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] npc, input bit rdy);
    bit pop, full, commit;
    rec_t h;
    @(negedge clk);
    diffen = en; diffPC = pc; diffInstr = instr; nextPC = npc; out_ready = rdy;
    #1;
    chk("step.valid", out_valid, m_count != 0);
    pop = (m_count != 0) && rdy;
    full = m_count == 8;
    if (pop) begin
      h = sb.pop_front();
      chk("head.pc", out_pc, h.pc);
      chk("head.instr", out_instr, h.instr);
      chk("head.npc", out_npc, h.npc);
      chk("head.seq", out_seq, h.seq);
    end
    commit = en && !m_halt;
    if (commit) begin
      if (!full || pop) begin
        sb.push_back('{pc, instr, npc, m_seq});
        m_count++;
`ifdef COMMIT_TRACE_HALT_EN
        if (instr == 32'h00100073) m_halt = 1;
`endif
      end else begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop++;
      end
      if (m_have && pc != m_lnpc) begin
        if (!m_chain) m_errpc = pc;
        m_chain = 1;
      end
      m_have = 1; m_lnpc = npc; m_seq++;
    end
    if (pop) m_count--;
    @(posedge clk);
    #2;
    diffen = 1'b0; out_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 1);
  endtask

  initial begin
    logic [31:0] pc;
    do_reset();
    #1;
    check_state("reset");
    chk("reset.out_pc", out_pc, 32'h0);
    chk("reset.out_seq", out_seq, 32'h0);

    // basic capture then in-order drain
    for (int i = 0; i < 3; i++) begin
      pc = 32'h80000000 + 32'(4 * i);
      step(1, pc, 32'h00000013 + 32'(i), pc + 32'd4, 0);
    end
    check_state("basic");
    chk("basic.out_pc", out_pc, 32'h80000000);
    chk("basic.out_seq", out_seq, 32'h0);
    drain(3);
    check_state("basic_drained");
    chk("empty.out_pc", out_pc, 32'h0);

    // overflow: 10 commits into 8 entries
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pc = 32'h80000000 + 32'(4 * i);
      step(1, pc, 32'hA0000000 + 32'(i), pc + 32'd4, 0);
    end
    check_state("ovf");
    chk("ovf.drop2", drop_cnt, 16'd2);
    drain(8);
    step(1, 32'h80000028, 32'hBEEF, 32'h8000002C, 0);
    chk("ovf.next_seq", out_seq, 32'd10);
    check_state("ovf_next");
    drain(1);

    // full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pc = 32'h80000000 + 32'(4 * i);
      step(1, pc, 32'hC0000000 + 32'(i), pc + 32'd4, 0);
    end
    step(1, 32'h80000020, 32'hCAFE, 32'h80000024, 1);
    check_state("fullpp");
    chk("fullpp.count8", count, 4'd8);
    chk("fullpp.ovf0", overflow, 1'b0);
    drain(8);
    check_state("fullpp_drained");

    // chain break capture
    do_reset();
    step(1, 32'h80000000, 32'h13, 32'h80000100, 1);
    step(1, 32'h80000004, 32'h13, 32'h80000008, 1);
    check_state("chain1");
    chk("chain1.errpc", err_pc, 32'h80000004);
    step(1, 32'h80000200, 32'h13, 32'h80000204, 1);
    drain(2);
    check_state("chain2");
    chk("chain2.errpc", err_pc, 32'h80000004);

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pc = 32'h80000000 + 32'(4 * i);
      step(1, pc, 32'h13, pc + 32'd4, 0);
    end
    chk("async.pre_count", count, 4'd5);
    #1 rst = 1'b0;
    #1;
    chk("async.valid", out_valid, 1'b0);
    chk("async.count", count, 4'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    step(1, 32'h90000000, 32'h13, 32'h90000004, 0);
    chk("async.seq0", out_seq, 32'd0);
    check_state("async_after");
    drain(1);

`ifdef COMMIT_TRACE_HALT_EN
    // ebreak freezes capture, drain still works
    do_reset();
    step(1, 32'h80000010, 32'h00100073, 32'h80000014, 0);
    step(1, 32'h80000014, 32'h13, 32'h80000018, 0);
    step(1, 32'h80000400, 32'h13, 32'h80000404, 0);
    step(1, 32'h80000404, 32'h13, 32'h80000408, 0);
    check_state("halt");
    chk("halt.count1", count, 4'd1);
    chk("halt.seq", out_seq, 32'd0);
    drain(1);
    check_state("halt_drained");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
